// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives operands and start,
// and the adder returns busy/done and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional macro SERIAL_ADDER_SAT_EN saturates sum on signed overflow.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    generate
        if ((DIGIT < 1) || (WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic                   accept;
    logic                   last;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_nxt;
    logic                   ovf_nxt;
    logic [WIDTH-1:0]       sum_nxt;

    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

`ifdef SERIAL_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                  input logic             ovf,
                                                  input logic             sign);
        if (ovf)
            return sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return val;
    endfunction
`endif

    // Start is honoured in IDLE and in the DONE cycle, never mid-operation.
    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    assign dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign res_cat = {dsum[DIGIT-1:0], res_sr};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign ovf_nxt = signed_ovf(a_sign, b_sign, res_nxt[WIDTH-1]);

`ifdef SERIAL_ADDER_SAT_EN
    assign sum_nxt = saturate(res_nxt, ovf_nxt, a_sign);
`else
    assign sum_nxt = res_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Operand/partial-result shifting; outputs only move on the final digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b ^ {WIDTH{bus.sub}};
            res_sr <= '0;
            carry  <= bus.sub | bus.cin;
            a_sign <= bus.a[WIDTH-1];
            b_sign <= bus.b[WIDTH-1] ^ bus.sub;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_nxt;
            carry  <= dsum[DIGIT];
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= sum_nxt;
                cout_q <= dsum[DIGIT];
                ovf_q  <= ovf_nxt;
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 16-bit/4-bit-digit scenarios plus an exhaustive
// sweep of a 3-bit/1-bit-digit instance against a signed behavioural model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   overlap  = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(16)) bus16 ();
    serial_adder_if #(.WIDTH(3))  bus3 ();

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    always @(negedge clk) begin
        if ((bus16.busy && bus16.done) || (bus3.busy && bus3.done))
            overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic c, output int lat, output int bcyc);
        bus16.a     = a;
        bus16.b     = b;
        bus16.sub   = s;
        bus16.cin   = c;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        lat  = 0;
        bcyc = bus16.busy ? 1 : 0;
        while (!bus16.done && lat < 20) begin
            tick();
            lat++;
            if (bus16.busy) bcyc++;
        end
    endtask

    initial begin
        int lat;
        int bcyc;
        int full;
        int sa;
        int sb;
        int r;
        logic [2:0] es;
        logic ec;
        logic eo;

        bus16.start = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;
        bus3.start  = 1'b0; bus3.sub  = 1'b0; bus3.cin  = 1'b0; bus3.a  = '0; bus3.b  = '0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus16.busy), 32'd0);
        check("rst_done", 32'(bus16.done), 32'd0);
        check("rst_sum",  32'(bus16.sum),  32'd0);
        check("rst_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: plain add, latency and busy length
        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, bcyc);
        check("add_latency", 32'(lat), 32'd4);
        check("add_busy_cycles", 32'(bcyc), 32'd4);
        check("add_sum", 32'(bus16.sum), 32'h2233);
        check("add_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'b00);
        tick();
        check("done_is_pulse", 32'(bus16.done), 32'd0);

        // 2: wrap
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcyc);
        check("wrap_sum", 32'(bus16.sum), 32'h0000);
        check("wrap_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'b10);

        // 3: signed overflow
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcyc);
`ifdef SERIAL_ADDER_SAT_EN
        check("ovf_sum", 32'(bus16.sum), 32'h7FFF);
`else
        check("ovf_sum", 32'(bus16.sum), 32'h8000);
`endif
        check("ovf_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'b01);

        // 4: subtract, cin ignored
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bcyc);
        check("sub_sum", 32'(bus16.sum), 32'hFFFE);
        check("sub_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'b00);
        run16(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bcyc);
`ifdef SERIAL_ADDER_SAT_EN
        check("subovf_sum", 32'(bus16.sum), 32'h8000);
`else
        check("subovf_sum", 32'(bus16.sum), 32'h7FFF);
`endif
        check("subovf_cout_ovf", {30'd0, bus16.cout, bus16.overflow}, 32'b11);

        // 5: start during RUN ignored, start in DONE accepted back-to-back
        bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.sub = 1'b0; bus16.cin = 1'b0;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        tick();
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.sub = 1'b1; bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0; bus16.sub = 1'b0;
        lat = 2;
        while (!bus16.done && lat < 20) begin
            tick();
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'd4);
        check("ignore_sum", 32'(bus16.sum), 32'h3333);
        bus16.a = 16'h0100; bus16.b = 16'h0023; bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        check("b2b_busy", 32'(bus16.busy), 32'd1);
        lat = 0;
        while (!bus16.done && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_latency", 32'(lat), 32'd4);
        check("b2b_sum", 32'(bus16.sum), 32'h0123);

        // 6a: reset in the middle of an operation
        bus16.a = 16'h5555; bus16.b = 16'h1111; bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(bus16.busy), 32'd0);
        check("midrst_done", 32'(bus16.done), 32'd0);
        check("midrst_sum", 32'(bus16.sum), 32'd0);
        tick();
        check("midrst_idle", {30'd0, bus16.busy, bus16.done}, 32'd0);
        run16(16'h0042, 16'h0001, 1'b0, 1'b1, lat, bcyc);
        check("postrst_latency", 32'(lat), 32'd4);
        check("postrst_sum", 32'(bus16.sum), 32'h0044);
        tick();

        // 6b: exhaustive 3-bit sweep
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int si = 0; si < 2; si++) begin
                        bus3.a     = 3'(ai);
                        bus3.b     = 3'(bi);
                        bus3.cin   = ci[0];
                        bus3.sub   = si[0];
                        bus3.start = 1'b1;
                        tick();
                        bus3.start = 1'b0;
                        lat = 0;
                        while (!bus3.done && lat < 20) begin
                            tick();
                            lat++;
                        end
                        if (si != 0) full = ai + ((~bi) & 7) + 1;
                        else         full = ai + bi + ci;
                        es = 3'(full & 7);
                        ec = ((full >> 3) & 1) != 0;
                        sa = (ai >= 4) ? ai - 8 : ai;
                        sb = (bi >= 4) ? bi - 8 : bi;
                        r  = (si != 0) ? sa - sb : sa + sb + ci;
                        eo = (r > 3) || (r < -4);
`ifdef SERIAL_ADDER_SAT_EN
                        if (eo) es = (sa < 0) ? 3'b100 : 3'b011;
`endif
                        check($sformatf("sweep_lat a=%0d b=%0d c=%0d s=%0d", ai, bi, ci, si),
                              32'(lat), 32'd3);
                        check($sformatf("sweep_sum a=%0d b=%0d c=%0d s=%0d", ai, bi, ci, si),
                              32'(bus3.sum), 32'(es));
                        check($sformatf("sweep_cout_ovf a=%0d b=%0d c=%0d s=%0d", ai, bi, ci, si),
                              {30'd0, bus3.cout, bus3.overflow}, {30'd0, ec, eo});
                    end
                end
            end
        end

        check("busy_done_overlap", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
